// File: rtl/hazard_pkg.sv
// Shared types and constants for the pipeline hazard controller.
// Holds the controller state encoding and the hard-wired zero register index.
package hazard_pkg;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    LOAD_WAIT = 2'd1,
    FLUSHING  = 2'd2
  } hz_state_e;

  localparam int REG_ZERO = 0;

  function automatic int max2(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/hazard_ctrl_unit_sat_counter.sv
// Saturating up-counter used for the stall and flush event statistics.
// Holds at all-ones instead of wrapping so long runs never read back as small counts.
module sat_counter #(
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         inc,
  output logic [W-1:0] q
);

  logic [W-1:0] q_reg;
  logic [W-1:0] q_next;

  always_comb begin
    q_next = q_reg;
    if (inc && (q_reg != {W{1'b1}})) begin
      q_next = q_reg + W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      q_reg <= '0;
    end else begin
      q_reg <= q_next;
    end
  end

  assign q = q_reg;

endmodule

// File: rtl/hazard_ctrl_unit.sv
// Stateful load-use / control-transfer hazard controller for the 5-stage pipeline.
// Multi-cycle load stalls and flush windows, memory-busy freeze, event counters.
module hazard_ctrl_unit
  import hazard_pkg::*;
#(
  parameter int REG_AW      = 5,
  parameter int LOAD_LAT    = 1,
  parameter int FLUSH_SLOTS = 1,
  parameter int CNT_W       = 16,
  parameter int ZERO_EXEMPT = 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              idex_mem_read,
  input  logic [REG_AW-1:0] idex_rt,
  input  logic [REG_AW-1:0] ifid_rs,
  input  logic [REG_AW-1:0] ifid_rt,
  input  logic              ifid_uses_rt,
  input  logic              jump,
  input  logic              jal,
  input  logic              jr,
  input  logic              branch_taken,
  input  logic              mem_busy,
  output logic              pc_write,
  output logic              ifid_write,
  output logic              stall_sel,
  output logic              flush,
  output logic              freeze,
  output logic [CNT_W-1:0]  stall_cnt,
  output logic [CNT_W-1:0]  flush_cnt
);

  localparam int CW = $clog2(max2(LOAD_LAT, FLUSH_SLOTS) + 1);
  localparam logic [CW-1:0] LOAD_INIT  = CW'(LOAD_LAT - 1);
  localparam logic [CW-1:0] FLUSH_INIT = CW'(FLUSH_SLOTS - 1);
  localparam logic [CW-1:0] CNT_ONE    = CW'(1);

  hz_state_e   state_reg, state_next;
  logic [CW-1:0] cnt_reg, cnt_next;

  logic hazard;
  logic xfer;
  logic zero_dest;

  // A load into the hard-wired zero register produces no usable value to wait for.
  assign zero_dest = (ZERO_EXEMPT != 0) && (idex_rt == REG_AW'(REG_ZERO));
  assign hazard    = idex_mem_read && !zero_dest &&
                     ((idex_rt == ifid_rs) || (ifid_uses_rt && (idex_rt == ifid_rt)));
  assign xfer      = jump || jal || jr || branch_taken;

  always_comb begin
    state_next = state_reg;
    cnt_next   = cnt_reg;
    pc_write   = 1'b1;
    ifid_write = 1'b1;
    stall_sel  = 1'b0;
    flush      = 1'b0;
    freeze     = 1'b0;

    if (reset) begin
      state_next = IDLE;
      cnt_next   = '0;
    end else if (mem_busy) begin
      // Everything holds, including the sequence position, so the stall/flush resumes intact.
      freeze     = 1'b1;
      pc_write   = 1'b0;
      ifid_write = 1'b0;
    end else begin
      unique case (state_reg)
        IDLE: begin
          if (hazard) begin
            pc_write   = 1'b0;
            ifid_write = 1'b0;
            stall_sel  = 1'b1;
            if (LOAD_LAT > 1) begin
              state_next = LOAD_WAIT;
              cnt_next   = LOAD_INIT;
            end
          end else if (xfer) begin
            flush = 1'b1;
            if (FLUSH_SLOTS > 1) begin
              state_next = FLUSHING;
              cnt_next   = FLUSH_INIT;
            end
          end
        end
        LOAD_WAIT: begin
          pc_write   = 1'b0;
          ifid_write = 1'b0;
          stall_sel  = 1'b1;
          cnt_next   = cnt_reg - CNT_ONE;
          if (cnt_reg == CNT_ONE) begin
            state_next = IDLE;
          end
        end
        FLUSHING: begin
          flush    = 1'b1;
          cnt_next = cnt_reg - CNT_ONE;
          if (cnt_reg == CNT_ONE) begin
            state_next = IDLE;
          end
        end
        default: begin
          state_next = IDLE;
          cnt_next   = '0;
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg <= IDLE;
      cnt_reg   <= '0;
    end else begin
      state_reg <= state_next;
      cnt_reg   <= cnt_next;
    end
  end

  sat_counter #(.W(CNT_W)) u_stall_cnt (
    .clk   (clk),
    .reset (reset),
    .inc   (stall_sel),
    .q     (stall_cnt)
  );

  sat_counter #(.W(CNT_W)) u_flush_cnt (
    .clk   (clk),
    .reset (reset),
    .inc   (flush),
    .q     (flush_cnt)
  );

endmodule

// File: tb/tb_hazard_ctrl_unit.sv
// Bench for hazard_ctrl_unit: two configurations driven in parallel and checked
// every cycle against a remaining-cycles model, plus literal counter checkpoints.
module tb_hazard_ctrl_unit;

  logic       clk = 1'b0;
  logic       reset;
  logic       idex_mem_read;
  logic [4:0] idex_rt, ifid_rs, ifid_rt;
  logic       ifid_uses_rt;
  logic       jump, jal, jr, branch_taken;
  logic       mem_busy;

  // Instance a: LOAD_LAT=1, FLUSH_SLOTS=1, CNT_W=2
  logic       pw_a, iw_a, ss_a, fl_a, fz_a;
  logic [1:0] sc_a, fc_a;
  // Instance b: LOAD_LAT=3, FLUSH_SLOTS=2, CNT_W=16
  logic        pw_b, iw_b, ss_b, fl_b, fz_b;
  logic [15:0] sc_b, fc_b;

  hazard_ctrl_unit #(.REG_AW(5), .LOAD_LAT(1), .FLUSH_SLOTS(1), .CNT_W(2), .ZERO_EXEMPT(1)) dut_a (
    .clk(clk), .reset(reset), .idex_mem_read(idex_mem_read), .idex_rt(idex_rt),
    .ifid_rs(ifid_rs), .ifid_rt(ifid_rt), .ifid_uses_rt(ifid_uses_rt),
    .jump(jump), .jal(jal), .jr(jr), .branch_taken(branch_taken), .mem_busy(mem_busy),
    .pc_write(pw_a), .ifid_write(iw_a), .stall_sel(ss_a), .flush(fl_a), .freeze(fz_a),
    .stall_cnt(sc_a), .flush_cnt(fc_a)
  );

  hazard_ctrl_unit #(.REG_AW(5), .LOAD_LAT(3), .FLUSH_SLOTS(2), .CNT_W(16), .ZERO_EXEMPT(1)) dut_b (
    .clk(clk), .reset(reset), .idex_mem_read(idex_mem_read), .idex_rt(idex_rt),
    .ifid_rs(ifid_rs), .ifid_rt(ifid_rt), .ifid_uses_rt(ifid_uses_rt),
    .jump(jump), .jal(jal), .jr(jr), .branch_taken(branch_taken), .mem_busy(mem_busy),
    .pc_write(pw_b), .ifid_write(iw_b), .stall_sel(ss_b), .flush(fl_b), .freeze(fz_b),
    .stall_cnt(sc_b), .flush_cnt(fc_b)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;

  // Model: per configuration, cycles of stall/flush still owed plus event totals.
  int lat[2]   = '{1, 3};
  int slots[2] = '{1, 2};
  int cmax[2]  = '{3, 65535};
  int stall_left[2] = '{0, 0};
  int flush_left[2] = '{0, 0};
  int scnt[2] = '{0, 0};
  int fcnt[2] = '{0, 0};

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s cycle=%0d actual=%0d required=%0d", name, cyc, act, exp);
    end
  endtask

  always @(negedge clk) begin
    logic hz, xf;
    logic [31:0] e_pw, e_iw, e_ss, e_fl, e_fz;
    logic [31:0] g_pw, g_iw, g_ss, g_fl, g_fz, g_sc, g_fc;
    string tag;
    hz = idex_mem_read && (idex_rt != 5'd0) &&
         ((idex_rt == ifid_rs) || (ifid_uses_rt && (idex_rt == ifid_rt)));
    xf = jump || jal || jr || branch_taken;
    for (int i = 0; i < 2; i++) begin
      tag = (i == 0) ? "a" : "b";
      e_pw = 1; e_iw = 1; e_ss = 0; e_fl = 0; e_fz = 0;
      if (reset) begin
        // forced defaults
      end else if (mem_busy) begin
        e_fz = 1; e_pw = 0; e_iw = 0;
      end else if (stall_left[i] > 0 || (flush_left[i] == 0 && hz)) begin
        e_ss = 1; e_pw = 0; e_iw = 0;
      end else if (flush_left[i] > 0 || xf) begin
        e_fl = 1;
      end
      if (i == 0) begin
        g_pw = 32'(pw_a); g_iw = 32'(iw_a); g_ss = 32'(ss_a); g_fl = 32'(fl_a);
        g_fz = 32'(fz_a); g_sc = 32'(sc_a); g_fc = 32'(fc_a);
      end else begin
        g_pw = 32'(pw_b); g_iw = 32'(iw_b); g_ss = 32'(ss_b); g_fl = 32'(fl_b);
        g_fz = 32'(fz_b); g_sc = 32'(sc_b); g_fc = 32'(fc_b);
      end
      check({"pc_write_", tag}, g_pw, e_pw);
      check({"ifid_write_", tag}, g_iw, e_iw);
      check({"stall_sel_", tag}, g_ss, e_ss);
      check({"flush_", tag}, g_fl, e_fl);
      check({"freeze_", tag}, g_fz, e_fz);
      check({"stall_cnt_", tag}, g_sc, 32'(scnt[i]));
      check({"flush_cnt_", tag}, g_fc, 32'(fcnt[i]));
      // Advance model to the state after the coming rising edge.
      if (reset) begin
        stall_left[i] = 0; flush_left[i] = 0; scnt[i] = 0; fcnt[i] = 0;
      end else if (!mem_busy) begin
        if (stall_left[i] > 0) stall_left[i]--;
        else if (flush_left[i] > 0) flush_left[i]--;
        else if (hz) stall_left[i] = lat[i] - 1;
        else if (xf) flush_left[i] = slots[i] - 1;
        if (e_ss == 1 && scnt[i] < cmax[i]) scnt[i]++;
        if (e_fl == 1 && fcnt[i] < cmax[i]) fcnt[i]++;
      end
    end
  end

  // xcode = {jump, jal, jr, branch_taken}
  task automatic drive(input logic mr, input logic [4:0] ert, input logic [4:0] rs,
                       input logic [4:0] rt, input logic ur, input logic [3:0] xcode,
                       input logic mb, input logic rst);
    reset = rst; idex_mem_read = mr; idex_rt = ert; ifid_rs = rs; ifid_rt = rt;
    ifid_uses_rt = ur; {jump, jal, jr, branch_taken} = xcode; mem_busy = mb;
    $display("cyc %0d: rst=%0b mr=%0b ex_rt=%0d rs=%0d rt=%0d urt=%0b xfer=%04b busy=%0b",
             cyc, rst, mr, ert, rs, rt, ur, xcode, mb);
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic idle(input int n);
    for (int k = 0; k < n; k++) drive(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 4'b0000, 1'b0, 1'b0);
  endtask

  initial begin
    reset = 1'b1; idex_mem_read = 1'b0; idex_rt = '0; ifid_rs = '0; ifid_rt = '0;
    ifid_uses_rt = 1'b0; jump = 1'b0; jal = 1'b0; jr = 1'b0; branch_taken = 1'b0;
    mem_busy = 1'b0;
    #1;
    drive(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 4'b0000, 1'b0, 1'b1);
    drive(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 4'b0000, 1'b0, 1'b1);
    check("reset_stall_cnt_b", 32'(sc_b), 0);
    check("reset_flush_cnt_b", 32'(fc_b), 0);

    // load r8 in EX, ID reads r8; load leaves EX after one cycle
    drive(1'b1, 5'd8, 5'd8, 5'd0, 1'b0, 4'b0000, 1'b0, 1'b0);
    check("single_stall_cnt_a", 32'(sc_a), 1);
    idle(4);
    check("lat3_stall_cnt_b", 32'(sc_b), 3);
    check("lat1_stall_cnt_a", 32'(sc_a), 1);

    // r0 destination is exempt; rt match without rt use is not a hazard
    drive(1'b1, 5'd0, 5'd0, 5'd0, 1'b1, 4'b0000, 1'b0, 1'b0);
    drive(1'b1, 5'd5, 5'd3, 5'd5, 1'b0, 4'b0000, 1'b0, 1'b0);
    check("no_stall_cnt_b", 32'(sc_b), 3);
    drive(1'b1, 5'd5, 5'd3, 5'd5, 1'b1, 4'b0000, 1'b0, 1'b0);
    idle(3);
    check("rt_stall_cnt_b", 32'(sc_b), 6);

    // jal pulse
    drive(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 4'b0100, 1'b0, 1'b0);
    idle(2);
    check("jal_flush_cnt_b", 32'(fc_b), 2);
    check("jal_flush_cnt_a", 32'(fc_a), 1);

    // hazard wins over a taken branch
    drive(1'b1, 5'd8, 5'd8, 5'd0, 1'b0, 4'b0001, 1'b0, 1'b0);
    idle(3);
    check("hz_br_flush_cnt_b", 32'(fc_b), 2);
    check("hz_br_stall_cnt_b", 32'(sc_b), 9);

    // memory busy in the middle of a 3-cycle stall
    drive(1'b1, 5'd8, 5'd8, 5'd0, 1'b0, 4'b0000, 1'b0, 1'b0);
    drive(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 4'b0000, 1'b1, 1'b0);
    drive(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 4'b0000, 1'b1, 1'b0);
    check("busy_hold_stall_cnt_b", 32'(sc_b), 10);
    idle(3);
    check("busy_stall_cnt_b", 32'(sc_b), 12);
    check("busy_sat_stall_cnt_a", 32'(sc_a), 3);

    // busy while idle with a pending hazard: freeze only
    drive(1'b1, 5'd8, 5'd8, 5'd0, 1'b0, 4'b0000, 1'b1, 1'b0);
    check("busy_idle_stall_cnt_b", 32'(sc_b), 12);

    // reset during the second FLUSHING cycle
    drive(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 4'b0100, 1'b0, 1'b0);
    drive(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 4'b0000, 1'b0, 1'b1);
    idle(1);
    check("rst_flush_cnt_b", 32'(fc_b), 0);
    check("rst_stall_cnt_b", 32'(sc_b), 0);
    check("rst_flush_out_b", 32'(fl_b), 0);

    // five consecutive hazards: small counter saturates
    for (int k = 0; k < 5; k++) drive(1'b1, 5'd8, 5'd8, 5'd0, 1'b0, 4'b0000, 1'b0, 1'b0);
    check("sat_stall_cnt_a", 32'(sc_a), 3);
    idle(3);
    check("sat_stall_cnt_b", 32'(sc_b), 6);
    check("sat_hold_stall_cnt_a", 32'(sc_a), 3);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
